wl_mux_streamer: RTL and testbench

- Second-generation WL pin-multiplexing transmitter. It accepts full P_NUM_INPUTS-bit wordline bitmaps over a ready/valid handshake and buffers them in a P_FIFO_DEPTH-frame FIFO.
- It serialises each frame as P_GROUP_W-bit groups on the external mux protocol (wl_data/wl_group_sel/wl_latch), then pulses the internal parallel link.
- New over the single-frame version: frame queueing with backpressure, sparse mode (all-zero groups skipped), a programmable inter-group gap, and descending send order.
- Sits between cim_array_ctrl and dac_ctrl/cim_macro inside snn_soc_top.

---
 rtl/wl_mux_streamer.sv | 249 ++++++++++++++++++++++++
 tb/tb_wl_mux_streamer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wl_mux_streamer.sv
// wl_mux_streamer: queues full wordline bitmaps in a small frame FIFO and
// serialises each frame as groups on the external mux interface
// (wl_data / wl_group_sel / wl_latch), then publishes the whole frame on the
// parallel link with a one-cycle valid pulse.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for a queued frame; pops it and latches the frame config
// SEND   | emits one group per cycle (latch visible the following cycle)
// GAP    | programmable idle spacing between successive latches
// DONE   | publishes the frame on wl_bitmap_out and pulses wl_valid_pulse_out
module wl_mux_streamer #(
    parameter int P_NUM_INPUTS = 64,
    parameter int P_GROUP_W    = 8,
    parameter int P_FIFO_DEPTH = 2,
    parameter int P_GAP_W      = 4,
    localparam int G     = (P_GROUP_W > 0) ? (P_NUM_INPUTS / P_GROUP_W) : 1,
    localparam int SEL_W = (G > 1) ? $clog2(G) : 1,
    localparam int LVL_W = (P_FIFO_DEPTH >= 1) ? $clog2(P_FIFO_DEPTH + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_NUM_INPUTS-1:0] wl_bitmap_in,
    input  logic                    wl_in_valid,
    output logic                    wl_in_ready,
    input  logic                    cfg_sparse_en,
    input  logic                    cfg_rev_order,
    input  logic [P_GAP_W-1:0]      cfg_gap,
    output logic [P_NUM_INPUTS-1:0] wl_bitmap_out,
    output logic                    wl_valid_pulse_out,
    output logic [P_GROUP_W-1:0]    wl_data,
    output logic [SEL_W-1:0]        wl_group_sel,
    output logic                    wl_latch,
    output logic                    wl_clear,
    output logic                    wl_busy,
    output logic [LVL_W-1:0]        fifo_level
);

    localparam int PTR_W = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;

    // Parameter sanity: the bitmap must split into a whole number of groups.
    generate
        if ((P_GROUP_W <= 0) || (P_NUM_INPUTS <= 0) || ((P_NUM_INPUTS % P_GROUP_W) != 0)) begin : g_bad_group
            $fatal(1, "wl_mux_streamer: P_NUM_INPUTS must be a positive multiple of P_GROUP_W");
        end
        if (P_FIFO_DEPTH < 1) begin : g_bad_depth
            $fatal(1, "wl_mux_streamer: P_FIFO_DEPTH must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [P_NUM_INPUTS-1:0] r_mem [P_FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]        r_level;

    logic                    w_push;
    logic                    w_pop;
    logic [P_NUM_INPUTS-1:0] w_head;

    state_t                  r_state;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(P_FIFO_DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    // Ready is forced low while reset is held so nothing is accepted then.
    assign wl_in_ready = ~rst & (r_level != LVL_W'(P_FIFO_DEPTH));
    assign w_push      = wl_in_valid & wl_in_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign fifo_level  = r_level;

    // Payload storage; no reset needed since reads are gated by the level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wl_bitmap_in;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Group selection helpers
    // ------------------------------------------------------------------
    // Forward order picks the lowest pending group, reverse the highest.
    function automatic logic [SEL_W-1:0] f_pick(input logic [G-1:0] mask, input logic rev);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < G; i++) begin
            if (rev) begin
                if (mask[i]) idx = SEL_W'(i);
            end else begin
                if (mask[G-1-i]) idx = SEL_W'(G - 1 - i);
            end
        end
        return idx;
    endfunction

    logic [P_NUM_INPUTS-1:0] r_buf;
    logic [G-1:0]            r_mask;
    logic [SEL_W-1:0]        r_idx;
    logic                    r_rev;
    logic [P_GAP_W-1:0]      r_gap;
    logic [P_GAP_W-1:0]      r_gap_cnt;

    logic [G-1:0]            w_init_mask;
    logic [G-1:0]            w_onehot;
    logic [G-1:0]            w_mask_next;
    logic [SEL_W-1:0]        w_next_idx;
    logic [P_GROUP_W-1:0]    w_grp_data;

    // Send mask for the frame at the FIFO head: every group when dense,
    // only groups with at least one set bit when sparse.
    always_comb begin
        w_init_mask = '0;
        for (int g = 0; g < G; g++) begin
            w_init_mask[g] = ~cfg_sparse_en | (|w_head[g*P_GROUP_W +: P_GROUP_W]);
        end
    end

    assign w_onehot    = G'(1) << r_idx;
    assign w_mask_next = r_mask & ~w_onehot;
    assign w_next_idx  = f_pick(w_mask_next, r_rev);
    assign w_grp_data  = r_buf[r_idx*P_GROUP_W +: P_GROUP_W];

    // ------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------
    logic                    r_latch;
    logic                    r_clear;
    logic                    r_pulse;
    logic                    r_busy;
    logic [P_GROUP_W-1:0]    r_data;
    logic [SEL_W-1:0]        r_sel;
    logic [P_NUM_INPUTS-1:0] r_bitmap_out;

    // Frame sequencer: pop, serialise groups with optional gaps, publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_buf        <= '0;
            r_mask       <= '0;
            r_idx        <= '0;
            r_rev        <= 1'b0;
            r_gap        <= '0;
            r_gap_cnt    <= '0;
            r_latch      <= 1'b0;
            r_clear      <= 1'b0;
            r_pulse      <= 1'b0;
            r_busy       <= 1'b0;
            r_data       <= '0;
            r_sel        <= '0;
            r_bitmap_out <= '0;
        end else begin
            r_latch <= 1'b0;
            r_clear <= 1'b0;
            r_pulse <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        // Config is frozen here for the whole frame.
                        r_buf   <= w_head;
                        r_rev   <= cfg_rev_order;
                        r_gap   <= cfg_gap;
                        r_mask  <= w_init_mask;
                        r_idx   <= f_pick(w_init_mask, cfg_rev_order);
                        r_busy  <= 1'b1;
                        r_clear <= cfg_sparse_en;
                        r_state <= (w_init_mask == '0) ? S_DONE : S_SEND;
                    end
                end

                S_SEND: begin
                    r_latch <= 1'b1;
                    r_data  <= w_grp_data;
                    r_sel   <= r_idx;
                    r_mask  <= w_mask_next;
                    r_idx   <= w_next_idx;
                    if (w_mask_next == '0) begin
                        r_state <= S_DONE;
                    end else if (r_gap != '0) begin
                        r_gap_cnt <= r_gap;
                        r_state   <= S_GAP;
                    end else begin
                        r_state <= S_SEND;
                    end
                end

                S_GAP: begin
                    // Down-counter: terminal count 1 hands back to SEND.
                    if (r_gap_cnt <= P_GAP_W'(1)) begin
                        r_state <= S_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - P_GAP_W'(1);
                    end
                end

                S_DONE: begin
                    r_pulse      <= 1'b1;
                    r_bitmap_out <= r_buf;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wl_latch           = r_latch;
    assign wl_clear           = r_clear;
    assign wl_valid_pulse_out = r_pulse;
    assign wl_busy            = r_busy;
    assign wl_data            = r_data;
    assign wl_group_sel       = r_sel;
    assign wl_bitmap_out      = r_bitmap_out;

endmodule

// File: tb/tb_wl_mux_streamer.sv
// Self-checking bench for wl_mux_streamer: a scoreboard of expected group
// latches and completed frames is filled as frames are offered and drained
// by a negedge monitor as the DUT produces them.
module tb_wl_mux_streamer;

    localparam int NI   = 64;
    localparam int GW   = 8;
    localparam int D    = 2;
    localparam int GAPW = 4;
    localparam int G    = NI / GW;

    logic            clk = 1'b0;
    logic            rst;
    logic [NI-1:0]   wl_bitmap_in;
    logic            wl_in_valid;
    logic            wl_in_ready;
    logic            cfg_sparse_en;
    logic            cfg_rev_order;
    logic [GAPW-1:0] cfg_gap;
    logic [NI-1:0]   wl_bitmap_out;
    logic            wl_valid_pulse_out;
    logic [GW-1:0]   wl_data;
    logic [2:0]      wl_group_sel;
    logic            wl_latch;
    logic            wl_clear;
    logic            wl_busy;
    logic [1:0]      fifo_level;

    wl_mux_streamer #(
        .P_NUM_INPUTS(NI),
        .P_GROUP_W   (GW),
        .P_FIFO_DEPTH(D),
        .P_GAP_W     (GAPW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wl_bitmap_in      (wl_bitmap_in),
        .wl_in_valid       (wl_in_valid),
        .wl_in_ready       (wl_in_ready),
        .cfg_sparse_en     (cfg_sparse_en),
        .cfg_rev_order     (cfg_rev_order),
        .cfg_gap           (cfg_gap),
        .wl_bitmap_out     (wl_bitmap_out),
        .wl_valid_pulse_out(wl_valid_pulse_out),
        .wl_data           (wl_data),
        .wl_group_sel      (wl_group_sel),
        .wl_latch          (wl_latch),
        .wl_clear          (wl_clear),
        .wl_busy           (wl_busy),
        .fifo_level        (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [2:0]    sel;
        logic [GW-1:0] data;
    } lat_t;

    lat_t          q_lat[$];
    logic [NI-1:0] q_frm[$];
    int            q_clr = 0;

    int lat_t_q[$];
    int pls_t_q[$];
    int clr_t_q[$];
    int busy_t_q[$];
    int n_lat = 0;
    int n_pls = 0;
    int max_lvl = 0;
    bit saw_full = 1'b0;

    lat_t          m_lat;
    logic [NI-1:0] m_frm;

    // Monitor: compares every latch, clear and frame pulse with the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (wl_latch) begin
                lat_t_q.push_back(cyc);
                n_lat++;
                if (q_lat.size() == 0) begin
                    chk("lat_extra", 64'(1), 64'(0));
                end else begin
                    m_lat = q_lat.pop_front();
                    chk("lat_sel", 64'(wl_group_sel), 64'(m_lat.sel));
                    chk("lat_data", 64'(wl_data), 64'(m_lat.data));
                end
            end
            if (wl_valid_pulse_out) begin
                pls_t_q.push_back(cyc);
                n_pls++;
                if (q_frm.size() == 0) begin
                    chk("pulse_extra", 64'(1), 64'(0));
                end else begin
                    m_frm = q_frm.pop_front();
                    chk("frame_out", wl_bitmap_out, m_frm);
                end
            end
            if (wl_clear) begin
                clr_t_q.push_back(cyc);
                chk("clear_expected", 64'(q_clr > 0), 64'(1));
                if (q_clr > 0) q_clr--;
            end
            if (wl_busy) busy_t_q.push_back(cyc);
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (wl_in_valid && !wl_in_ready) saw_full = 1'b1;
        end
    end

    // Reference order of groups for one frame under the config it will use.
    task automatic expect_frame(input logic [NI-1:0] bm, input bit sp, input bit rv);
        int g;
        logic [GW-1:0] d;
        for (int k = 0; k < G; k++) begin
            g = rv ? (G - 1 - k) : k;
            d = bm[g*GW +: GW];
            if (!sp || d != '0) q_lat.push_back({3'(g), d});
        end
        q_frm.push_back(bm);
        if (sp) q_clr++;
    endtask

    // Offer one frame (called at a negedge); acc is the acceptance edge.
    task automatic send(input logic [NI-1:0] bm, input bit sp, input bit rv, output int acc);
        int n;
        n = 0;
        acc = -1;
        wl_bitmap_in = bm;
        wl_in_valid  = 1'b1;
        while (!wl_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wl_in_ready) begin
            chk("send_timeout", 64'(0), 64'(1));
        end else begin
            acc = cyc + 1;
            expect_frame(bm, sp, rv);
            @(negedge clk);
        end
        wl_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((q_frm.size() != 0 || wl_busy || fifo_level != 0) && n < 2000);
        chk("drain_frames", 64'(q_frm.size()), 64'(0));
        chk("drain_latches", 64'(q_lat.size()), 64'(0));
    endtask

    task automatic clr_rec();
        lat_t_q.delete();
        pls_t_q.delete();
        clr_t_q.delete();
        busy_t_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, base, n, pls_before;
        logic [NI-1:0] bm;

        rst           = 1'b1;
        wl_bitmap_in  = '0;
        wl_in_valid   = 1'b0;
        cfg_sparse_en = 1'b0;
        cfg_rev_order = 1'b0;
        cfg_gap       = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(wl_in_ready), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_busy", 64'(wl_busy), 64'(0));
        chk("rst_latch", 64'(wl_latch), 64'(0));
        chk("rst_pulse", 64'(wl_valid_pulse_out), 64'(0));
        chk("rst_bitmap", wl_bitmap_out, 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(wl_in_ready), 64'(1));

        // Dense single frame with timing
        clr_rec();
        send(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, a);
        wait_idle();
        chk("d_nlat", 64'(lat_t_q.size()), 64'(8));
        if (lat_t_q.size() == 8) begin
            chk("d_first_lat", 64'(lat_t_q[0]), 64'(a + 2));
            chk("d_last_lat", 64'(lat_t_q[7]), 64'(a + 9));
        end
        chk("d_npls", 64'(pls_t_q.size()), 64'(1));
        if (pls_t_q.size() == 1) chk("d_pls_t", 64'(pls_t_q[0]), 64'(a + 10));
        chk("d_nbusy", 64'(busy_t_q.size()), 64'(9));
        if (busy_t_q.size() == 9) begin
            chk("d_busy_first", 64'(busy_t_q[0]), 64'(a + 1));
            chk("d_busy_last", 64'(busy_t_q[8]), 64'(a + 9));
        end
        chk("d_no_clear", 64'(clr_t_q.size()), 64'(0));
        chk("d_bitmap_hold", wl_bitmap_out, 64'h0123_4567_89AB_CDEF);

        // Sparse + reverse
        cfg_sparse_en = 1'b1;
        cfg_rev_order = 1'b1;
        clr_rec();
        send(64'h00FF_0000_0000_0011, 1'b1, 1'b1, a);
        wait_idle();
        chk("s_nlat", 64'(lat_t_q.size()), 64'(2));
        chk("s_nclr", 64'(clr_t_q.size()), 64'(1));
        if (clr_t_q.size() == 1) chk("s_clr_t", 64'(clr_t_q[0]), 64'(a + 1));
        if (lat_t_q.size() == 2 && pls_t_q.size() == 1)
            chk("s_pls_t", 64'(pls_t_q[0]), 64'(lat_t_q[1] + 1));

        // Sparse all-zero frame
        clr_rec();
        send(64'h0, 1'b1, 1'b1, a);
        wait_idle();
        chk("z_nlat", 64'(lat_t_q.size()), 64'(0));
        chk("z_nclr", 64'(clr_t_q.size()), 64'(1));
        chk("z_npls", 64'(pls_t_q.size()), 64'(1));
        if (pls_t_q.size() == 1) chk("z_pls_t", 64'(pls_t_q[0]), 64'(a + 2));

        // Gap 3, dense forward
        cfg_sparse_en = 1'b0;
        cfg_rev_order = 1'b0;
        cfg_gap       = 4'd3;
        clr_rec();
        bm = {$urandom, $urandom};
        send(bm, 1'b0, 1'b0, a);
        wait_idle();
        chk("g_nlat", 64'(lat_t_q.size()), 64'(8));
        if (lat_t_q.size() == 8) begin
            chk("g_first_lat", 64'(lat_t_q[0]), 64'(a + 2));
            for (int i = 1; i < 8; i++)
                chk("g_spacing", 64'(lat_t_q[i] - lat_t_q[i-1]), 64'(4));
            if (pls_t_q.size() == 1) chk("g_pls_t", 64'(pls_t_q[0]), 64'(lat_t_q[7] + 1));
        end

        // Backpressure: 4 back-to-back frames into a 2-deep FIFO
        cfg_gap  = '0;
        clr_rec();
        saw_full = 1'b0;
        max_lvl  = 0;
        for (int f = 0; f < 4; f++) begin
            bm = {$urandom, $urandom};
            send(bm, 1'b0, 1'b0, a);
        end
        wait_idle();
        chk("bp_saw_full", 64'(saw_full), 64'(1));
        chk("bp_max_level", 64'(max_lvl), 64'(D));
        chk("bp_npls", 64'(pls_t_q.size()), 64'(4));
        if (pls_t_q.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("bp_pls_spacing", 64'(pls_t_q[i] - pls_t_q[i-1]), 64'(10));

        // Config change after pop only affects the next frame
        clr_rec();
        send(64'hA5A5_0000_5A5A_00FF, 1'b0, 1'b0, a);
        n = 0;
        while (!wl_busy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("cfg_busy_seen", 64'(wl_busy), 64'(1));
        cfg_sparse_en = 1'b1;
        cfg_rev_order = 1'b1;
        cfg_gap       = 4'd2;
        send(64'h1100_0000_2200_0033, 1'b1, 1'b1, b);
        wait_idle();
        chk("cfg_nlat", 64'(lat_t_q.size()), 64'(11));
        if (lat_t_q.size() == 11) begin
            for (int i = 1; i < 8; i++)
                chk("cfg_a_spacing", 64'(lat_t_q[i] - lat_t_q[i-1]), 64'(1));
            chk("cfg_b_spacing1", 64'(lat_t_q[9] - lat_t_q[8]), 64'(3));
            chk("cfg_b_spacing2", 64'(lat_t_q[10] - lat_t_q[9]), 64'(3));
        end
        chk("cfg_nclr", 64'(clr_t_q.size()), 64'(1));

        // Reset during the 4th latch with one frame queued
        cfg_sparse_en = 1'b0;
        cfg_rev_order = 1'b0;
        cfg_gap       = '0;
        clr_rec();
        send({$urandom, $urandom}, 1'b0, 1'b0, a);
        send({$urandom, $urandom}, 1'b0, 1'b0, b);
        base = n_lat;
        n = 0;
        while (n_lat < base + 4 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("r_reached_lat4", 64'(n_lat - base), 64'(4));
        chk("r_queued", 64'(fifo_level), 64'(1));
        pls_before = n_pls;
        rst = 1'b1;
        q_lat.delete();
        q_frm.delete();
        q_clr = 0;
        @(negedge clk);
        chk("r_ready_in_rst", 64'(wl_in_ready), 64'(0));
        chk("r_level", 64'(fifo_level), 64'(0));
        chk("r_bitmap", wl_bitmap_out, 64'(0));
        chk("r_busy", 64'(wl_busy), 64'(0));
        chk("r_latch", 64'(wl_latch), 64'(0));
        chk("r_pulse", 64'(wl_valid_pulse_out), 64'(0));
        chk("r_data", 64'(wl_data), 64'(0));
        chk("r_sel", 64'(wl_group_sel), 64'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("r_ready_after", 64'(wl_in_ready), 64'(1));
        repeat (12) @(negedge clk);
        chk("r_no_pulse", 64'(n_pls), 64'(pls_before));
        chk("r_level_after", 64'(fifo_level), 64'(0));
        clr_rec();
        send(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, a);
        wait_idle();
        chk("r_new_frame_pls", 64'(n_pls), 64'(pls_before + 1));
        if (pls_t_q.size() == 1) chk("r_new_pls_t", 64'(pls_t_q[0]), 64'(a + 10));

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
